xspread_cmplx: RTL
==================

// Module: xspread_cmplx
// PURPOSE
//  Transmit-side complex spreader; the counterpart of the tree-adder correlator.
//  - Accepts one complex symbol plus an Nops-long vector of complex +/-1 operators.
//  - Emits Nops chips serially, one per clock: chip k = symbol * op[k].
//  - Sits between the symbol mapper and the chip-rate filter.
//  - A second symbol is buffered, so back-to-back symbols stream with no gaps.
// PARAMETERS
//  Nops     4   chips per symbol (>=1, any integer)
//  IBWID    16  symbol I/Q bit-width, two's complement
//  IS_CMPLX 0   1: full complex operators; 0: imag operator part ignored
// PORTS
//  iClk      in   1          clock; single clock domain
//  iRst      in   1          reset, asynchronous, active-high
//  iDI       in   IBWID      symbol real part
//  iDQ       in   IBWID      symbol imag part
//  iVecOpI   in   Nops*2     operator real parts; op k at [2k+1:2k]
//  iVecOpQ   in   Nops*2     operator imag parts; ignored when IS_CMPLX=0
//  iND       in   1          symbol valid; accepted only when oRdy=1
//  oRdy      out  1          pending slot empty
//  oChipI    out  IBWID+2    chip real part
//  oChipQ    out  IBWID+2    chip imag part
//  oDV       out  1          chip valid
//  oFirst    out  1          chip 0 of a symbol (qualified by oDV)
//  oLast     out  1          chip Nops-1 of a symbol (qualified by oDV)
//  oOvf      out  1          1-clk pulse: iND=1 while oRdy=0; symbol dropped
// BEHAVIOUR
//  - Reset: every output register is cleared (oChipI/Q, oDV, oFirst, oLast, oOvf = 0).
//    Active and pending slots are emptied, chip counter = 0, oRdy = 1.
//    iND is ignored while iRst=1.
//  - Reset mid-symbol: remaining chips and any pending symbol are discarded.
//    No oDV follows reset.
//  - Operator coding: 2'b01 = +1, 2'b11 = -1, anything else = 0 (the chip part is 0).
//  - Chip arithmetic, inputs sign-extended to IBWID+2:
//    - IS_CMPLX=1: I = a*DI - b*DQ, Q = a*DQ + b*DI (a = opI[k], b = opQ[k]).
//    - IS_CMPLX=0: I = a*DI, Q = a*DQ.
//    - Results are exact; no saturation. Negating -2^(IBWID-1) is exact.
//  - Chip order: k = 0 first, up to k = Nops-1.
//  - Slots and states:
//    - ACTIVE holds {DI, DQ, ops, chip counter}; PENDING holds one symbol.
//    - States: IDLE (ACTIVE empty) -> RUN (issue one chip per clk).
//    - At the last chip, RUN -> RUN if PENDING is full (PENDING moves to ACTIVE); else RUN -> IDLE.
//  - Acceptance: iND & oRdy captures the symbol.
//    - It goes to ACTIVE if ACTIVE is empty, or is issuing its last chip while PENDING is empty.
//    - Otherwise it goes to PENDING.
//  - oRdy = ~PENDING_full, combinational from the current state.
//    - In the cycle PENDING moves to ACTIVE, oRdy is still 0; it rises the next clock.
//  - Latency: a chip issued at edge t appears with oDV=1 after edge t+2.
//    - Two registered stages: operator select / partial products, then sum / output.
//    - A symbol accepted into an empty ACTIVE at edge t gives its first oDV after edge t+2.
//    - Throughput is 1 chip/clk; consecutive symbols have no oDV gap.
//  - oDV=0 cycles: oChipI/Q hold their last value. oFirst and oLast are 0.
//  - Nops=1: every chip has oFirst=oLast=1. A new symbol can be accepted every clock.
//  - Counter width is clog2(Nops). The counter wraps from Nops-1 to 0 without overshoot.
// STRUCTURE
//  - Shared package xspread_pkg holds:
//    - OP_ADD=2'b01, OP_SUB=2'b11.
//    - The clog2 function.
//    - A signed +/-1/0 operator-apply function, shared with the tree-adder correlator.
//  - Sub-module xchip_mult: one complex chip multiplier.
//    - Two register stages; IS_CMPLX passed down.
//    - Takes 2-bit op pair + IBWID I/Q; outputs IBWID+2 I/Q.
//  - The top level holds the slot registers, the counter/FSM and the first/last/valid delay line.
// TESTING  (IBWID=16, Nops=4, IS_CMPLX=1 unless noted)
//  1. Symbol (1000, -500), opI=all 01, opQ=all 00:
//     -> 4 chips of (1000, -500), 2 clks after acceptance. oFirst on chip 0, oLast on chip 3.
//  2. Symbol (1000, 200), opI={01,11,00,00}, opQ={00,00,01,11} (chip 3..0):
//     -> chips (1000,200), (-1000,-200), (-200,1000), (200,-1000).
//  3. Symbol (-32768, -32768), opI=11, opQ=11:
//     -> chip (0, 65536) exact. IS_CMPLX=0 -> (32768, 32768).
//  4. Three symbols on consecutive clocks:
//     -> 1st and 2nd accepted, 3rd gives oOvf=1 for 1 clk.
//     -> Exactly 8 contiguous oDV chips; oRdy re-rises 1 clk after the 2nd symbol starts.
//  5. iRst asserted after chip 1 of a symbol, with one symbol pending:
//     -> outputs 0 asynchronously, no further oDV, oRdy=1 after release.
//  6. Nops=1, iND held high for 10 clks:
//     -> 10 back-to-back chips, all with oFirst=oLast=1, no oOvf.

Source files
------------

// File: rtl/xspread_pkg.sv
// Shared definitions for the complex spreader and the tree-adder correlator:
// operator codes, a constant clog2, and the signed +1/-1/0 operator apply.
package xspread_pkg;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b11;

    // Tag travelling alongside each chip through the multiplier pipeline.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } chip_tag_t;

    // Number of bits needed to count 0..n-1; 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Apply a 2-bit operator to a sign-extended value: +x, -x or 0.
    // Callers sign-extend into 64 bits and slice the result back down.
    function automatic logic signed [63:0] op_apply(input logic [1:0] op,
                                                    input logic signed [63:0] x);
        case (op)
            OP_ADD:  return x;
            OP_SUB:  return -x;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/xchip_mult.sv
// One complex chip multiplier: symbol (d_i, d_q) times operator (op_i, op_q).
// Stage 1 registers the four partial products, stage 2 the sum/difference.
// Each stage only loads on its enable, so the output holds between chips.
module xchip_mult
    import xspread_pkg::*;
#(
    parameter int unsigned IBWID    = 16,
    parameter bit          IS_CMPLX = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce1,
    input  logic               ce2,
    input  logic [1:0]         op_i,
    input  logic [1:0]         op_q,
    input  logic [IBWID-1:0]   d_i,
    input  logic [IBWID-1:0]   d_q,
    output logic [IBWID+1:0]   chip_i,
    output logic [IBWID+1:0]   chip_q
);

    localparam int unsigned OW = IBWID + 2;

    logic [1:0]           op_b;
    logic signed [63:0]   x_i;
    logic signed [63:0]   x_q;
    logic signed [OW-1:0] p_ai;
    logic signed [OW-1:0] p_bq;
    logic signed [OW-1:0] p_aq;
    logic signed [OW-1:0] p_bi;

    // Sign-extend the symbol and drop the imaginary operator in real-only mode.
    always_comb begin
        op_b = IS_CMPLX ? op_q : 2'b00;
        x_i  = 64'(signed'(d_i));
        x_q  = 64'(signed'(d_q));
    end

    // Stage 1: partial products a*DI, b*DQ, a*DQ, b*DI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_ai <= '0;
            p_bq <= '0;
            p_aq <= '0;
            p_bi <= '0;
        end else if (ce1) begin
            p_ai <= OW'(op_apply(op_i, x_i));
            p_bq <= OW'(op_apply(op_b, x_q));
            p_aq <= OW'(op_apply(op_i, x_q));
            p_bi <= OW'(op_apply(op_b, x_i));
        end
    end

    // Stage 2: I = a*DI - b*DQ, Q = a*DQ + b*DI; IBWID+2 bits keeps it exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chip_i <= '0;
            chip_q <= '0;
        end else if (ce2) begin
            chip_i <= p_ai - p_bq;
            chip_q <= p_aq + p_bi;
        end
    end

endmodule

// File: rtl/xspread_cmplx.sv
// Transmit-side complex spreader. Holds an ACTIVE symbol being chipped out and
// one PENDING symbol so back-to-back symbols stream without gaps. Each clock in
// RUN issues one chip (operator k) into the two-stage multiplier.
module xspread_cmplx
    import xspread_pkg::*;
#(
    parameter int unsigned Nops     = 4,
    parameter int unsigned IBWID    = 16,
    parameter bit          IS_CMPLX = 1'b0
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [IBWID-1:0]    iDI,
    input  logic [IBWID-1:0]    iDQ,
    input  logic [Nops*2-1:0]   iVecOpI,
    input  logic [Nops*2-1:0]   iVecOpQ,
    input  logic                iND,
    output logic                oRdy,
    output logic [IBWID+1:0]    oChipI,
    output logic [IBWID+1:0]    oChipQ,
    output logic                oDV,
    output logic                oFirst,
    output logic                oLast,
    output logic                oOvf
);

    localparam int unsigned     CW       = (clog2(Nops) < 1) ? 1 : clog2(Nops);
    localparam logic [CW-1:0]   CNT_LAST = CW'(Nops - 1);
    localparam logic [0:0]      S_IDLE   = 1'b0;
    localparam logic [0:0]      S_RUN    = 1'b1;

    logic [0:0]          state;
    logic [CW-1:0]       cnt;
    logic [IBWID-1:0]    act_di;
    logic [IBWID-1:0]    act_dq;
    logic [Nops*2-1:0]   act_opi;
    logic [Nops*2-1:0]   act_opq;

    logic                pnd_full;
    logic [IBWID-1:0]    pnd_di;
    logic [IBWID-1:0]    pnd_dq;
    logic [Nops*2-1:0]   pnd_opi;
    logic [Nops*2-1:0]   pnd_opq;

    logic                issue;
    logic                last;
    logic                accept;
    logic                to_act;
    logic                to_pnd;
    logic [1:0]          sel_opi;
    logic [1:0]          sel_opq;
    chip_tag_t           tag1;

    // Issue/accept decisions; a new symbol bypasses PENDING when ACTIVE frees up.
    always_comb begin
        issue   = (state == S_RUN);
        last    = issue && (cnt == CNT_LAST);
        oRdy    = ~pnd_full;
        accept  = iND && ~pnd_full;
        to_act  = accept && (!issue || last);
        to_pnd  = accept && !to_act;
        sel_opi = act_opi[int'(cnt)*2 +: 2];
        sel_opq = act_opq[int'(cnt)*2 +: 2];
    end

    // ACTIVE slot and chip counter / FSM; PENDING wins over a new symbol at the last chip.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            act_di  <= '0;
            act_dq  <= '0;
            act_opi <= '0;
            act_opq <= '0;
        end else if (last && pnd_full) begin
            state   <= S_RUN;
            cnt     <= '0;
            act_di  <= pnd_di;
            act_dq  <= pnd_dq;
            act_opi <= pnd_opi;
            act_opq <= pnd_opq;
        end else if (to_act) begin
            state   <= S_RUN;
            cnt     <= '0;
            act_di  <= iDI;
            act_dq  <= iDQ;
            act_opi <= iVecOpI;
            act_opq <= iVecOpQ;
        end else if (last) begin
            state   <= S_IDLE;
            cnt     <= '0;
        end else if (issue) begin
            cnt     <= cnt + 1'b1;
        end
    end

    // PENDING slot: filled by an accepted symbol that cannot go straight to ACTIVE.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            pnd_full <= 1'b0;
            pnd_di   <= '0;
            pnd_dq   <= '0;
            pnd_opi  <= '0;
            pnd_opq  <= '0;
        end else if (to_pnd) begin
            pnd_full <= 1'b1;
            pnd_di   <= iDI;
            pnd_dq   <= iDQ;
            pnd_opi  <= iVecOpI;
            pnd_opq  <= iVecOpQ;
        end else if (last && pnd_full) begin
            pnd_full <= 1'b0;
        end
    end

    // Valid/first/last delay line matching the multiplier latency, plus overflow pulse.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            tag1   <= '0;
            oDV    <= 1'b0;
            oFirst <= 1'b0;
            oLast  <= 1'b0;
            oOvf   <= 1'b0;
        end else begin
            tag1.vld   <= issue;
            tag1.first <= issue && (cnt == '0);
            tag1.last  <= last;
            oDV        <= tag1.vld;
            oFirst     <= tag1.first;
            oLast      <= tag1.last;
            oOvf       <= iND && pnd_full;
        end
    end

    xchip_mult #(
        .IBWID    (IBWID),
        .IS_CMPLX (IS_CMPLX)
    ) u_mult (
        .clk    (iClk),
        .rst    (iRst),
        .ce1    (issue),
        .ce2    (tag1.vld),
        .op_i   (sel_opi),
        .op_q   (sel_opq),
        .d_i    (act_di),
        .d_q    (act_dq),
        .chip_i (oChipI),
        .chip_q (oChipQ)
    );

endmodule
